// File: rtl/cache_req_sequencer_if.sv
// Request, response and cache-side signals of the cache request sequencer.
// The slave modport is the sequencer; the master modport is the CPU and cache around it.
interface cache_req_sequencer_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 11
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [1:0]            rsp_level;
  logic [ADDR_WIDTH-1:0] cache_addr;
  logic                  cache_read;
  logic [DATA_WIDTH-1:0] cache_read_data;
  logic                  cache_l1_hit;
  logic                  cache_l2_hit;

  modport slave (
    input  req_valid, req_addr, rsp_ready, cache_read_data, cache_l1_hit, cache_l2_hit,
    output req_ready, rsp_valid, rsp_data, rsp_level, cache_addr, cache_read
  );

  modport master (
    output req_valid, req_addr, rsp_ready, cache_read_data, cache_l1_hit, cache_l2_hit,
    input  req_ready, rsp_valid, rsp_data, rsp_level, cache_addr, cache_read
  );
endinterface

// File: rtl/cache_req_sequencer.sv
// Buffers CPU load requests, issues one read strobe per request to the L1/L2 cache,
// returns data plus hit level, and keeps saturating access/hit/miss counters.
module cache_req_sequencer #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 11,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_req_sequencer_if.slave bus,
  input  logic                 stat_clear,
  output logic [CNT_WIDTH-1:0] stat_accesses,
  output logic [CNT_WIDTH-1:0] stat_l1_hits,
  output logic [CNT_WIDTH-1:0] stat_l2_hits,
  output logic [CNT_WIDTH-1:0] stat_misses,
  output logic                 busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]        count_reg;
  logic                  fifo_empty, fifo_full, push, pop;
  logic [ADDR_WIDTH-1:0] cur_addr_reg;
  logic                  rsp_valid_reg;
  logic [DATA_WIDTH-1:0] rsp_data_reg;
  logic [1:0]            rsp_level_reg;
  logic                  capture;
  logic [3:0]            inc;

  assign fifo_empty    = (count_reg == '0);
  assign fifo_full     = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
  assign push          = bus.req_valid && !fifo_full;
  assign bus.req_ready = !fifo_full;

  assign bus.cache_read = (state_reg == ISSUE);
  assign bus.cache_addr = cur_addr_reg;
  assign bus.rsp_valid  = rsp_valid_reg;
  assign bus.rsp_data   = rsp_data_reg;
  assign bus.rsp_level  = rsp_level_reg;
  assign busy           = (state_reg != IDLE) || !fifo_empty;

  // Storage array carries no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= bus.req_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = RESP;
      RESP: begin
        // Chain straight into the next issue to keep the 3-cycle response cadence.
        if (bus.rsp_ready) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = ISSUE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr_reg  <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_level_reg <= 2'd0;
    end else begin
      if (pop)
        cur_addr_reg <= fifo_mem[rd_ptr_reg];
      if (state_reg == CAPTURE) begin
        rsp_valid_reg <= 1'b1;
        rsp_data_reg  <= bus.cache_read_data;
        rsp_level_reg <= bus.cache_l1_hit ? 2'd0 : (bus.cache_l2_hit ? 2'd1 : 2'd2);
      end else if (state_reg == RESP && bus.rsp_ready) begin
        rsp_valid_reg <= 1'b0;
      end
    end
  end

  // Counter order: accesses, L1 hits, L2 hits, memory fills.
  assign capture = (state_reg == CAPTURE);
  assign inc[0]  = capture;
  assign inc[1]  = capture && bus.cache_l1_hit;
  assign inc[2]  = capture && !bus.cache_l1_hit && bus.cache_l2_hit;
  assign inc[3]  = capture && !bus.cache_l1_hit && !bus.cache_l2_hit;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_stat
      logic [CNT_WIDTH-1:0] cnt_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          cnt_reg <= '0;
        else if (stat_clear)
          cnt_reg <= '0;
        else if (inc[gi] && cnt_reg != '1)
          cnt_reg <= cnt_reg + CNT_WIDTH'(1);
      end
    end
  endgenerate

  assign stat_accesses = g_stat[0].cnt_reg;
  assign stat_l1_hits  = g_stat[1].cnt_reg;
  assign stat_l2_hits  = g_stat[2].cnt_reg;
  assign stat_misses   = g_stat[3].cnt_reg;
endmodule

// File: tb/tb_cache_req_sequencer.sv
// Directed bench for cache_req_sequencer: a default instance plus a 4-bit-counter
// instance for saturation, with a simple cache stub and a read-strobe monitor.
module tb_cache_req_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  cache_req_sequencer_if #(.ADDR_WIDTH(11), .DATA_WIDTH(11)) m ();
  cache_req_sequencer_if #(.ADDR_WIDTH(11), .DATA_WIDTH(11)) s ();

  logic        m_clear, s_clear, m_busy, s_busy;
  logic [15:0] m_acc, m_l1, m_l2, m_miss;
  logic [3:0]  s_acc, s_l1, s_l2, s_miss;

  // Cache stub: constant data, or data derived from the address to track ordering.
  logic        addr_data;
  logic [10:0] stub_data;
  assign m.cache_read_data = addr_data ? (m.cache_addr ^ 11'h5A5) : stub_data;

  cache_req_sequencer #(.ADDR_WIDTH(11), .DATA_WIDTH(11), .FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .bus(m.slave), .stat_clear(m_clear),
    .stat_accesses(m_acc), .stat_l1_hits(m_l1), .stat_l2_hits(m_l2),
    .stat_misses(m_miss), .busy(m_busy)
  );

  cache_req_sequencer #(.ADDR_WIDTH(11), .DATA_WIDTH(11), .FIFO_DEPTH(4), .CNT_WIDTH(4)) u_sat (
    .clk(clk), .rst(rst), .bus(s.slave), .stat_clear(s_clear),
    .stat_accesses(s_acc), .stat_l1_hits(s_l1), .stat_l2_hits(s_l2),
    .stat_misses(s_miss), .busy(s_busy)
  );

  // Records every issued address and counts back-to-back strobes.
  logic [10:0] issued [$];
  logic        prev_read = 1'b0;
  int          back_to_back = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_read = 1'b0;
    end else begin
      if (m.cache_read) begin
        issued.push_back(m.cache_addr);
        if (prev_read) back_to_back++;
      end
      prev_read = m.cache_read;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic single_req(input logic [10:0] addr, input logic l1, input logic l2,
                            input logic [10:0] data, input logic [1:0] lvl, input string tag);
    issued.delete();
    addr_data = 1'b0;
    stub_data = data;
    m.cache_l1_hit = l1;
    m.cache_l2_hit = l2;
    m.req_addr = addr;
    m.req_valid = 1'b1;
    chk({tag, "_req_ready"}, m.req_ready, 1);
    step();
    m.req_valid = 1'b0;
    chk({tag, "_busy_e0"}, m_busy, 1);
    chk({tag, "_read_e0"}, m.cache_read, 0);
    step();
    chk({tag, "_read_e1"}, m.cache_read, 1);
    chk({tag, "_addr_e1"}, m.cache_addr, addr);
    step();
    chk({tag, "_read_e2"}, m.cache_read, 0);
    chk({tag, "_addr_e2"}, m.cache_addr, addr);
    chk({tag, "_valid_e2"}, m.rsp_valid, 0);
    step();
    chk({tag, "_valid_e3"}, m.rsp_valid, 1);
    chk({tag, "_data"}, m.rsp_data, data);
    chk({tag, "_level"}, m.rsp_level, lvl);
    $display("rsp %s addr=0x%0h data=0x%0h level=%0d", tag, addr, m.rsp_data, m.rsp_level);
    m.rsp_ready = 1'b1;
    step();
    m.rsp_ready = 1'b0;
    chk({tag, "_valid_done"}, m.rsp_valid, 0);
    chk({tag, "_busy_done"}, m_busy, 0);
    chk({tag, "_strobes"}, issued.size(), 1);
  endtask

  task automatic collect(input int n, input logic [10:0] exp_d [5], input string tag);
    int got = 0;
    int cyc = 0;
    int last = 0;
    while (got < n && cyc < 60) begin
      if (m.rsp_valid) begin
        chk($sformatf("%s_data%0d", tag, got), m.rsp_data, exp_d[got]);
        chk($sformatf("%s_level%0d", tag, got), m.rsp_level, 0);
        if (got > 0) chk($sformatf("%s_gap%0d", tag, got), cyc - last, 3);
        $display("rsp %s #%0d data=0x%0h level=%0d", tag, got, m.rsp_data, m.rsp_level);
        last = cyc;
        got++;
      end
      step();
      cyc++;
    end
    chk({tag, "_count"}, got, n);
  endtask

  logic [10:0] a4 [5]  = '{11'h100, 11'h201, 11'h302, 11'h403, 11'h504};
  logic [10:0] d4 [5]  = '{11'h4A5, 11'h7A4, 11'h6A7, 11'h1A6, 11'h0A1};
  logic [10:0] d7 [5]  = '{11'h70F, 11'h4F0, 11'h000, 11'h000, 11'h000};
  logic [10:0] b3 [3]  = '{11'h011, 11'h022, 11'h033};

  initial begin
    int cyc;
    int extra;
    int accepted;
    m.req_valid = 1'b0; m.req_addr = '0; m.rsp_ready = 1'b0;
    m.cache_l1_hit = 1'b0; m.cache_l2_hit = 1'b0;
    s.req_valid = 1'b0; s.req_addr = '0; s.rsp_ready = 1'b0;
    s.cache_l1_hit = 1'b0; s.cache_l2_hit = 1'b0; s.cache_read_data = '0;
    m_clear = 1'b0; s_clear = 1'b0; addr_data = 1'b0; stub_data = '0;

    // Reset state, observed before any clock edge.
    #2 rst = 1'b1;
    #2;
    chk("rst_req_ready", m.req_ready, 1);
    chk("rst_rsp_valid", m.rsp_valid, 0);
    chk("rst_rsp_data", m.rsp_data, 0);
    chk("rst_rsp_level", m.rsp_level, 0);
    chk("rst_cache_addr", m.cache_addr, 0);
    chk("rst_cache_read", m.cache_read, 0);
    chk("rst_acc", m_acc, 0);
    chk("rst_busy", m_busy, 0);
    step();
    rst = 1'b0;
    step();

    // Miss, L1 hit, L2 hit on the same address.
    single_req(11'h123, 1'b0, 1'b0, 11'h3F3, 2'd2, "miss");
    chk("miss_stat_acc", m_acc, 1);
    chk("miss_stat_miss", m_miss, 1);
    single_req(11'h123, 1'b1, 1'b0, 11'h055, 2'd0, "l1");
    chk("l1_stat_l1", m_l1, 1);
    single_req(11'h123, 1'b0, 1'b1, 11'h2C1, 2'd1, "l2");
    chk("l2_stat_l2", m_l2, 1);
    chk("l2_stat_acc", m_acc, 3);
    chk("l2_stat_miss", m_miss, 1);

    // Five back-to-back pushes against a stalled consumer.
    issued.delete();
    addr_data = 1'b1;
    m.cache_l1_hit = 1'b1;
    m.cache_l2_hit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      m.req_valid = 1'b1;
      m.req_addr = a4[i];
      chk($sformatf("fill_ready%0d", i), m.req_ready, 1);
      step();
    end
    chk("fill_full", m.req_ready, 0);
    chk("fill_valid", m.rsp_valid, 1);
    chk("fill_data", m.rsp_data, 11'h4A5);
    m.req_addr = 11'h7FF;
    step();
    step();
    m.req_valid = 1'b0;
    chk("stall_full", m.req_ready, 0);
    chk("stall_valid", m.rsp_valid, 1);
    chk("stall_data", m.rsp_data, 11'h4A5);
    chk("stall_strobes", issued.size(), 1);
    m.rsp_ready = 1'b1;
    collect(5, d4, "drain");
    step();
    step();
    chk("drain_busy", m_busy, 0);
    chk("drain_strobes", issued.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < issued.size()) chk($sformatf("drain_order%0d", i), issued[i], a4[i]);
    chk("drain_stat_acc", m_acc, 8);
    chk("drain_stat_l1", m_l1, 6);
    m.rsp_ready = 1'b0;

    // Reset while in CAPTURE with two entries queued.
    addr_data = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m.req_valid = 1'b1;
      m.req_addr = b3[i];
      step();
    end
    m.req_valid = 1'b0;
    chk("cap_busy", m_busy, 1);
    chk("cap_read", m.cache_read, 0);
    rst = 1'b1;
    #1;
    issued.delete();
    chk("caprst_read", m.cache_read, 0);
    chk("caprst_valid", m.rsp_valid, 0);
    chk("caprst_busy", m_busy, 0);
    chk("caprst_ready", m.req_ready, 1);
    chk("caprst_acc", m_acc, 0);
    chk("caprst_l1", m_l1, 0);
    step();
    rst = 1'b0;
    m.rsp_ready = 1'b1;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      if (m.rsp_valid) extra++;
      step();
    end
    chk("caprst_no_rsp", extra, 0);
    chk("caprst_no_read", issued.size(), 0);
    chk("caprst_idle", m_busy, 0);
    m.rsp_ready = 1'b0;

    // Reset during ISSUE must drop the strobe without waiting for a clock.
    m.req_valid = 1'b1;
    m.req_addr = 11'h0F0;
    step();
    m.req_valid = 1'b0;
    step();
    chk("issrst_pre", m.cache_read, 1);
    rst = 1'b1;
    #1;
    chk("issrst_read", m.cache_read, 0);
    step();
    rst = 1'b0;

    // Reset during RESP must drop the pending response at once.
    m.req_valid = 1'b1;
    m.req_addr = 11'h0F1;
    stub_data = 11'h6B6;
    step();
    m.req_valid = 1'b0;
    step();
    step();
    step();
    chk("resprst_pre", m.rsp_valid, 1);
    rst = 1'b1;
    #1;
    chk("resprst_valid", m.rsp_valid, 0);
    chk("resprst_data", m.rsp_data, 0);
    step();
    rst = 1'b0;
    step();

    // Push on the same edge as the IDLE->ISSUE pop.
    issued.delete();
    addr_data = 1'b1;
    m.req_valid = 1'b1;
    m.req_addr = 11'h2AA;
    step();
    m.req_addr = 11'h155;
    step();
    m.req_valid = 1'b0;
    chk("same_read", m.cache_read, 1);
    chk("same_addr", m.cache_addr, 11'h2AA);
    chk("same_ready", m.req_ready, 1);
    m.rsp_ready = 1'b1;
    collect(2, d7, "same");
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      if (m.rsp_valid) extra++;
      step();
    end
    chk("same_no_dup", extra, 0);
    chk("same_strobes", issued.size(), 2);
    if (issued.size() == 2) begin
      chk("same_order0", issued[0], 11'h2AA);
      chk("same_order1", issued[1], 11'h155);
    end
    m.rsp_ready = 1'b0;

    // Saturation on the 4-bit counter instance.
    s.cache_l1_hit = 1'b1;
    s.cache_read_data = 11'h111;
    s.rsp_ready = 1'b1;
    s.req_addr = 11'h3C3;
    s.req_valid = 1'b1;
    accepted = 0;
    cyc = 0;
    while (accepted < 16 && cyc < 300) begin
      if (s.req_ready) accepted++;
      step();
      cyc++;
    end
    s.req_valid = 1'b0;
    chk("sat_accepted", accepted, 16);
    cyc = 0;
    while (s_busy && cyc < 60) begin
      step();
      cyc++;
    end
    chk("sat_drain", s_busy, 0);
    chk("sat_l1", s_l1, 15);
    chk("sat_acc", s_acc, 15);
    chk("sat_l2", s_l2, 0);
    chk("sat_miss", s_miss, 0);
    s_clear = 1'b1;
    step();
    s_clear = 1'b0;
    chk("clr_acc", s_acc, 0);
    chk("clr_l1", s_l1, 0);

    // Clear on the CAPTURE edge wins over the increment.
    s.req_valid = 1'b1;
    step();
    s.req_valid = 1'b0;
    step();
    step();
    s_clear = 1'b1;
    step();
    s_clear = 1'b0;
    chk("clrcap_acc", s_acc, 0);
    chk("clrcap_l1", s_l1, 0);
    chk("clrcap_valid", s.rsp_valid, 1);
    chk("clrcap_data", s.rsp_data, 11'h111);
    step();
    s.req_valid = 1'b1;
    step();
    s.req_valid = 1'b0;
    cyc = 0;
    while (s_busy && cyc < 20) begin
      step();
      cyc++;
    end
    chk("recount_drain", s_busy, 0);
    chk("recount_acc", s_acc, 1);
    chk("recount_l1", s_l1, 1);

    chk("no_back_to_back", back_to_back, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cache_req_sequencer.md
Name: cache_req_sequencer

Overview:
Request front-end sitting directly upstream of the 2-way L1/L2 cache system. It accepts CPU load requests over a valid/ready handshake and buffers them in a small FIFO. It issues one single-cycle read pulse per request to the cache, captures the cache's registered result, and returns data plus hit level over a valid/ready response channel. It also maintains saturating access/hit/miss statistics counters.

Parameters:
ADDR_WIDTH, 11, request and cache address width
DATA_WIDTH, 11, cache data width
FIFO_DEPTH, 4, request FIFO entries (power of two, >=2)
CNT_WIDTH, 16, width of each statistics counter

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  request present
req_ready  output  1  FIFO can accept (= !full)
req_addr  input  ADDR_WIDTH  request address
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_data  output  DATA_WIDTH  returned data
rsp_level  output  2  0=L1 hit, 1=L2 hit, 2=memory fill, 3 unused
cache_addr  output  ADDR_WIDTH  address to cache
cache_read  output  1  one-cycle read strobe to cache
cache_read_data  input  DATA_WIDTH  cache read_data (registered in cache)
cache_l1_hit  input  1  cache l1_hit
cache_l2_hit  input  1  cache l2_hit
stat_clear  input  1  synchronous clear of all counters
stat_accesses  output  CNT_WIDTH  completed cache reads
stat_l1_hits  output  CNT_WIDTH  L1 hit count
stat_l2_hits  output  CNT_WIDTH  L2 hit count
stat_misses  output  CNT_WIDTH  memory-fill count
busy  output  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Reset (async): FIFO empty, FSM=IDLE. req_ready=1, rsp_valid=0, rsp_data=0, rsp_level=0, cache_addr=0, cache_read=0, all stat_* =0, busy=0. cache_read drops immediately on rst assertion, mid-operation included. An in-flight request or pending response is discarded.
- FIFO: push on req_valid&&req_ready. Pop only on FSM transitions into ISSUE. Push and pop in the same cycle leaves the count unchanged. No bypass: an entry pushed at edge E is poppable no earlier than E+1. Pointers wrap modulo FIFO_DEPTH. When full, req_ready=0 and req_valid is ignored.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
  - IDLE: if FIFO non-empty, pop the head into cur_addr -> ISSUE.
  - ISSUE: cache_read=1, cache_addr=cur_addr for exactly one cycle -> CAPTURE.
  - CAPTURE: cache_read=0, cache_addr holds cur_addr. At the edge, register rsp_data=cache_read_data. Register rsp_level: 0 if cache_l1_hit, else 1 if cache_l2_hit, else 2. Update counters. Set rsp_valid=1 -> RESP.
  - RESP: rsp_valid, rsp_data and rsp_level held stable until rsp_ready. On handshake, rsp_valid=0. If the FIFO is non-empty, pop -> ISSUE directly; otherwise -> IDLE.
- Latency: request accepted at edge E0 into an empty idle block gives pop at E1, cache samples at E2, rsp_valid=1 after E3. With rsp_ready held high, sustained throughput is one response per 3 cycles.
- cache_read is never high in two consecutive cycles. At most one request is outstanding at the cache.
- Counters update at the CAPTURE edge: stat_accesses+1, plus exactly one of l1/l2/misses +1. Each counter saturates at 2^CNT_WIDTH-1.
- stat_clear zeroes all counters at the next edge and has priority over a same-edge increment, which is lost. stat_clear does not affect the FIFO, FSM or responses.
- busy is combinational: (state!=IDLE) || !fifo_empty.

Test Plan:
- Reset then single req_addr=0x123. Stub returns l1=0, l2=0, data=0x3F3 in CAPTURE -> rsp_valid rises 3 cycles after accept, rsp_data=0x3F3, rsp_level=2, stat_misses=1, stat_accesses=1, cache_read high exactly 1 cycle with cache_addr=0x123.
- Same address again, stub l1_hit=1, data=0x055 -> rsp_level=0, rsp_data=0x055, stat_l1_hits=1. Then stub l2_hit=1 only -> rsp_level=1, stat_l2_hits=1.
- Push 5 requests back-to-back with rsp_ready=0 (FIFO_DEPTH=4) -> after the first pops, 4 buffered and req_ready=0. FSM holds RESP, rsp_data stable. Releasing rsp_ready -> all 5 responses delivered in push order, one per 3 cycles.
- Assert rst while in CAPTURE with 2 entries queued -> cache_read=0 and rsp_valid=0 immediately. FIFO empty, counters 0, no response emitted after rst release until new requests arrive.
- CNT_WIDTH=4: 16 L1 hits -> stat_l1_hits=15 (saturated) and stat_accesses=15. stat_clear on the same edge as a CAPTURE -> all counters 0 next cycle.
- Push at the same edge as an IDLE->ISSUE pop with FIFO holding 1 entry -> count stays 1, the pushed address is issued next, and no request is lost or duplicated.
